// File: rtl/br_mask_ctrl.sv
// br_mask_ctrl
//   Branch-mask controller and tag allocator for the branch stack (one per core).
//   Tracks in-flight branch checkpoints in a mask. Each newly dispatched branch
//   gets a one-hot tag, and the controller records the mask that branch depends on.
//   On resolve it either clears the branch's bit (correct prediction) or rolls the
//   mask back to that branch's dependency mask (misprediction).
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   br_dispatch_i      a branch dispatches this cycle
//   br_rs_vld_i        a branch resolves this cycle
//   br_rs_1hot_i       one-hot tag of the resolving branch
//   br_rs_correct_i    1 = predicted correctly, 0 = mispredicted
//   br_mask_o          registered in-flight mask, one bit per stack entry
//   br_new_1hot_o      tag offered to the dispatching branch (combinational)
//   br_dep_mask_o      mask carried by the dispatching instruction (combinational)
//   br_accept_o        dispatch accepted this cycle
//   br_full_o          every checkpoint in use
//   br_cnt_o           number of in-flight branches
//   br_state_o         resolve state broadcast (NO_BR / PR_CORRECT / PR_WRONG)
//   br_1hot_o          qualified resolving tag broadcast
//   rc_sel_o           checkpoint to restore on mispredict, else 0
//   squash_mask_o      branches killed by a mispredict, including itself

module br_mask_ctrl #(
    parameter int BR_NUM     = 4,
    parameter int BR_STATE_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       br_dispatch_i,
    input  logic                       br_rs_vld_i,
    input  logic [BR_NUM-1:0]          br_rs_1hot_i,
    input  logic                       br_rs_correct_i,
    output logic [BR_NUM-1:0]          br_mask_o,
    output logic [BR_NUM-1:0]          br_new_1hot_o,
    output logic [BR_NUM-1:0]          br_dep_mask_o,
    output logic                       br_accept_o,
    output logic                       br_full_o,
    output logic [$clog2(BR_NUM):0]    br_cnt_o,
    output logic [BR_STATE_W-1:0]      br_state_o,
    output logic [BR_NUM-1:0]          br_1hot_o,
    output logic [BR_NUM-1:0]          rc_sel_o,
    output logic [BR_NUM-1:0]          squash_mask_o
);

    localparam int CNT_W = $clog2(BR_NUM) + 1;

    localparam logic [BR_STATE_W-1:0] NO_BR      = BR_STATE_W'(0);
    localparam logic [BR_STATE_W-1:0] PR_CORRECT = BR_STATE_W'(1);
    localparam logic [BR_STATE_W-1:0] PR_WRONG   = BR_STATE_W'(2);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [BR_NUM-1:0] mask_q, mask_d;
    logic [BR_NUM-1:0] dep_q [BR_NUM];
    logic [BR_NUM-1:0] dep_d [BR_NUM];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rs_onehot;
    logic              rs_ok;
    logic              rs_good;
    logic              rs_bad;
    logic              full;
    logic              accept;
    logic              found;
    logic [BR_NUM-1:0] new_1hot;
    logic [BR_NUM-1:0] dep_mask;
    logic [BR_NUM-1:0] rb_dep;
    logic [BR_NUM-1:0] squash;
    logic [CNT_W-1:0]  rb_cnt;

    // Resolve qualification, allocation and broadcast outputs
    always_comb begin
        rs_onehot = (br_rs_1hot_i != '0) &&
                    ((br_rs_1hot_i & (br_rs_1hot_i - BR_NUM'(1))) == '0);
        rs_ok     = br_rs_vld_i && rs_onehot && ((br_rs_1hot_i & mask_q) != '0);
        rs_good   = rs_ok && br_rs_correct_i;
        rs_bad    = rs_ok && !br_rs_correct_i;

        full = &mask_q;

        // Lowest free bit comes from the registered mask only, so a tag freed by a
        // resolve in this cycle is not handed out until the following cycle.
        new_1hot = '0;
        found    = 1'b0;
        for (int i = 0; i < BR_NUM; i++) begin
            if (!found && !mask_q[i]) begin
                new_1hot[i] = 1'b1;
                found       = 1'b1;
            end
        end

        accept   = br_dispatch_i && !full && !rs_bad;
        dep_mask = rs_good ? (mask_q & ~br_rs_1hot_i) : mask_q;

        // Dependency mask of the resolving branch (tag is one-hot when it matters)
        rb_dep = '0;
        for (int j = 0; j < BR_NUM; j++) begin
            if (br_rs_1hot_i[j]) begin
                rb_dep = rb_dep | dep_q[j];
            end
        end

        rb_cnt = '0;
        for (int i = 0; i < BR_NUM; i++) begin
            rb_cnt = rb_cnt + CNT_W'(rb_dep[i]);
        end

        squash = rs_bad ? (mask_q & ~rb_dep) : '0;
    end

    // Next-state
    always_comb begin
        mask_d = mask_q;
        dep_d  = dep_q;
        cnt_d  = cnt_q;

        if (rs_bad) begin
            mask_d = rb_dep;
            cnt_d  = rb_cnt;
            for (int j = 0; j < BR_NUM; j++) begin
                if (squash[j]) begin
                    dep_d[j] = '0;
                end
            end
        end else begin
            if (rs_good) begin
                mask_d = mask_d & ~br_rs_1hot_i;
                cnt_d  = cnt_d - CNT_ONE;
                for (int j = 0; j < BR_NUM; j++) begin
                    dep_d[j] = dep_d[j] & ~br_rs_1hot_i;
                end
            end
            if (accept) begin
                mask_d = mask_d | new_1hot;
                cnt_d  = cnt_d + CNT_ONE;
                for (int j = 0; j < BR_NUM; j++) begin
                    if (new_1hot[j]) begin
                        dep_d[j] = dep_mask;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            cnt_q  <= '0;
            for (int j = 0; j < BR_NUM; j++) begin
                dep_q[j] <= '0;
            end
        end else begin
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            for (int j = 0; j < BR_NUM; j++) begin
                dep_q[j] <= dep_d[j];
            end
        end
    end

    assign br_mask_o     = mask_q;
    assign br_new_1hot_o = new_1hot;
    assign br_dep_mask_o = dep_mask;
    assign br_accept_o   = accept;
    assign br_full_o     = full;
    assign br_cnt_o      = cnt_q;
    assign br_state_o    = rs_good ? PR_CORRECT : (rs_bad ? PR_WRONG : NO_BR);
    assign br_1hot_o     = rs_ok ? br_rs_1hot_i : '0;
    assign rc_sel_o      = rs_bad ? br_rs_1hot_i : '0;
    assign squash_mask_o = squash;

endmodule

// File: tb/tb_br_mask_ctrl.sv
module tb_br_mask_ctrl;

    logic       clk;
    logic       rst;
    logic       br_dispatch_i;
    logic       br_rs_vld_i;
    logic [3:0] br_rs_1hot_i;
    logic       br_rs_correct_i;
    logic [3:0] br_mask_o;
    logic [3:0] br_new_1hot_o;
    logic [3:0] br_dep_mask_o;
    logic       br_accept_o;
    logic       br_full_o;
    logic [2:0] br_cnt_o;
    logic [1:0] br_state_o;
    logic [3:0] br_1hot_o;
    logic [3:0] rc_sel_o;
    logic [3:0] squash_mask_o;

    int n_cmp = 0;
    int n_err = 0;

    br_mask_ctrl #(.BR_NUM(4), .BR_STATE_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .br_dispatch_i   (br_dispatch_i),
        .br_rs_vld_i     (br_rs_vld_i),
        .br_rs_1hot_i    (br_rs_1hot_i),
        .br_rs_correct_i (br_rs_correct_i),
        .br_mask_o       (br_mask_o),
        .br_new_1hot_o   (br_new_1hot_o),
        .br_dep_mask_o   (br_dep_mask_o),
        .br_accept_o     (br_accept_o),
        .br_full_o       (br_full_o),
        .br_cnt_o        (br_cnt_o),
        .br_state_o      (br_state_o),
        .br_1hot_o       (br_1hot_o),
        .rc_sel_o        (rc_sel_o),
        .squash_mask_o   (squash_mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and leave inputs idle, sampling 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        br_dispatch_i   = 1'b0;
        br_rs_vld_i     = 1'b0;
        br_rs_1hot_i    = 4'b0000;
        br_rs_correct_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (br_mask_o !== 4'b0000) begin n_err++; $display("FAIL rst_mask got %b exp 0000", br_mask_o); end
        n_cmp++; if (br_full_o !== 1'b0) begin n_err++; $display("FAIL rst_full got %b exp 0", br_full_o); end
        n_cmp++; if (br_cnt_o !== 3'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", br_cnt_o); end
        n_cmp++; if (br_state_o !== 2'b00) begin n_err++; $display("FAIL rst_state got %b exp 00", br_state_o); end
        n_cmp++; if (br_1hot_o !== 4'b0000) begin n_err++; $display("FAIL rst_1hot got %b exp 0000", br_1hot_o); end
        n_cmp++; if (rc_sel_o !== 4'b0000) begin n_err++; $display("FAIL rst_rcsel got %b exp 0000", rc_sel_o); end
        n_cmp++; if (squash_mask_o !== 4'b0000) begin n_err++; $display("FAIL rst_squash got %b exp 0000", squash_mask_o); end
        n_cmp++; if (br_accept_o !== 1'b0) begin n_err++; $display("FAIL rst_accept got %b exp 0", br_accept_o); end
    endtask

    task automatic test_fill();
        logic [3:0] exp_new   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_dep   [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        logic [3:0] exp_mask  [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            br_dispatch_i = 1'b1;
            #1;
            n_cmp++; if (br_accept_o !== 1'b1) begin n_err++; $display("FAIL fill_accept[%0d] got %b exp 1", i, br_accept_o); end
            n_cmp++; if (br_new_1hot_o !== exp_new[i]) begin n_err++; $display("FAIL fill_new[%0d] got %b exp %b", i, br_new_1hot_o, exp_new[i]); end
            n_cmp++; if (br_dep_mask_o !== exp_dep[i]) begin n_err++; $display("FAIL fill_dep[%0d] got %b exp %b", i, br_dep_mask_o, exp_dep[i]); end
            tick();
            n_cmp++; if (br_mask_o !== exp_mask[i]) begin n_err++; $display("FAIL fill_mask[%0d] got %b exp %b", i, br_mask_o, exp_mask[i]); end
            n_cmp++; if (br_cnt_o !== 3'(i + 1)) begin n_err++; $display("FAIL fill_cnt[%0d] got %0d exp %0d", i, br_cnt_o, i + 1); end
        end
        n_cmp++; if (br_full_o !== 1'b1) begin n_err++; $display("FAIL full_flag got %b exp 1", br_full_o); end
        br_dispatch_i = 1'b1;
        #1;
        n_cmp++; if (br_accept_o !== 1'b0) begin n_err++; $display("FAIL full_accept got %b exp 0", br_accept_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b1111) begin n_err++; $display("FAIL full_mask got %b exp 1111", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd4) begin n_err++; $display("FAIL full_cnt got %0d exp 4", br_cnt_o); end
    endtask

    // Continues from the full mask left by test_fill
    task automatic test_mispredict();
        br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0010; br_rs_correct_i = 1'b0;
        #1;
        n_cmp++; if (rc_sel_o !== 4'b0010) begin n_err++; $display("FAIL mp_rcsel got %b exp 0010", rc_sel_o); end
        n_cmp++; if (squash_mask_o !== 4'b1110) begin n_err++; $display("FAIL mp_squash got %b exp 1110", squash_mask_o); end
        n_cmp++; if (br_state_o !== 2'b10) begin n_err++; $display("FAIL mp_state got %b exp 10", br_state_o); end
        n_cmp++; if (br_1hot_o !== 4'b0010) begin n_err++; $display("FAIL mp_1hot got %b exp 0010", br_1hot_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0001) begin n_err++; $display("FAIL mp_mask got %b exp 0001", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd1) begin n_err++; $display("FAIL mp_cnt got %0d exp 1", br_cnt_o); end
    endtask

    // Starts from mask 0001
    task automatic test_correct();
        br_dispatch_i = 1'b1; tick();
        br_dispatch_i = 1'b1; tick();
        n_cmp++; if (br_mask_o !== 4'b0111) begin n_err++; $display("FAIL cr_setup got %b exp 0111", br_mask_o); end
        br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0010; br_rs_correct_i = 1'b1;
        #1;
        n_cmp++; if (br_state_o !== 2'b01) begin n_err++; $display("FAIL cr_state got %b exp 01", br_state_o); end
        n_cmp++; if (br_1hot_o !== 4'b0010) begin n_err++; $display("FAIL cr_1hot got %b exp 0010", br_1hot_o); end
        n_cmp++; if (squash_mask_o !== 4'b0000) begin n_err++; $display("FAIL cr_squash got %b exp 0000", squash_mask_o); end
        n_cmp++; if (rc_sel_o !== 4'b0000) begin n_err++; $display("FAIL cr_rcsel got %b exp 0000", rc_sel_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0101) begin n_err++; $display("FAIL cr_mask got %b exp 0101", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd2) begin n_err++; $display("FAIL cr_cnt got %0d exp 2", br_cnt_o); end
        // dep_r[2] must now be 0001: mispredicting tag 2 reveals it
        br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0100; br_rs_correct_i = 1'b0;
        #1;
        n_cmp++; if (squash_mask_o !== 4'b0100) begin n_err++; $display("FAIL cr_dep2_squash got %b exp 0100", squash_mask_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0001) begin n_err++; $display("FAIL cr_dep2_mask got %b exp 0001", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd1) begin n_err++; $display("FAIL cr_dep2_cnt got %0d exp 1", br_cnt_o); end
    endtask

    // Starts from mask 0001
    task automatic test_back_to_back();
        br_dispatch_i = 1'b1; tick();
        n_cmp++; if (br_mask_o !== 4'b0011) begin n_err++; $display("FAIL bb_setup got %b exp 0011", br_mask_o); end
        br_dispatch_i = 1'b1; br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0001; br_rs_correct_i = 1'b1;
        #1;
        n_cmp++; if (br_accept_o !== 1'b1) begin n_err++; $display("FAIL bb_accept got %b exp 1", br_accept_o); end
        n_cmp++; if (br_new_1hot_o !== 4'b0100) begin n_err++; $display("FAIL bb_new got %b exp 0100", br_new_1hot_o); end
        n_cmp++; if (br_dep_mask_o !== 4'b0010) begin n_err++; $display("FAIL bb_dep got %b exp 0010", br_dep_mask_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0110) begin n_err++; $display("FAIL bb_mask got %b exp 0110", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd2) begin n_err++; $display("FAIL bb_cnt got %0d exp 2", br_cnt_o); end
        // entry 2 recorded dep 0010
        br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0100; br_rs_correct_i = 1'b0;
        #1;
        n_cmp++; if (squash_mask_o !== 4'b0100) begin n_err++; $display("FAIL bb_dep2_squash got %b exp 0100", squash_mask_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0010) begin n_err++; $display("FAIL bb_dep2_mask got %b exp 0010", br_mask_o); end

        do_reset();
        br_dispatch_i = 1'b1; tick();
        br_dispatch_i = 1'b1; tick();
        n_cmp++; if (br_mask_o !== 4'b0011) begin n_err++; $display("FAIL bbw_setup got %b exp 0011", br_mask_o); end
        br_dispatch_i = 1'b1; br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0010; br_rs_correct_i = 1'b0;
        #1;
        n_cmp++; if (br_accept_o !== 1'b0) begin n_err++; $display("FAIL bbw_accept got %b exp 0", br_accept_o); end
        n_cmp++; if (squash_mask_o !== 4'b0010) begin n_err++; $display("FAIL bbw_squash got %b exp 0010", squash_mask_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0001) begin n_err++; $display("FAIL bbw_mask got %b exp 0001", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd1) begin n_err++; $display("FAIL bbw_cnt got %0d exp 1", br_cnt_o); end
    endtask

    // Starts from mask 0001
    task automatic test_unqualified();
        br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0100; br_rs_correct_i = 1'b1;
        #1;
        n_cmp++; if (br_state_o !== 2'b00) begin n_err++; $display("FAIL uq_state got %b exp 00", br_state_o); end
        n_cmp++; if (br_1hot_o !== 4'b0000) begin n_err++; $display("FAIL uq_1hot got %b exp 0000", br_1hot_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0001) begin n_err++; $display("FAIL uq_mask got %b exp 0001", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd1) begin n_err++; $display("FAIL uq_cnt got %0d exp 1", br_cnt_o); end
        // not one-hot, although it overlaps the mask
        br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0011; br_rs_correct_i = 1'b0;
        #1;
        n_cmp++; if (br_state_o !== 2'b00) begin n_err++; $display("FAIL uq_nh_state got %b exp 00", br_state_o); end
        n_cmp++; if (rc_sel_o !== 4'b0000) begin n_err++; $display("FAIL uq_nh_rcsel got %b exp 0000", rc_sel_o); end
        tick();
        n_cmp++; if (br_mask_o !== 4'b0001) begin n_err++; $display("FAIL uq_nh_mask got %b exp 0001", br_mask_o); end
        // valid low
        br_rs_vld_i = 1'b0; br_rs_1hot_i = 4'b0001; br_rs_correct_i = 1'b0;
        #1;
        n_cmp++; if (squash_mask_o !== 4'b0000) begin n_err++; $display("FAIL uq_nv_squash got %b exp 0000", squash_mask_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        br_dispatch_i = 1'b1; tick();
        n_cmp++; if (br_mask_o !== 4'b0011) begin n_err++; $display("FAIL rm_setup got %b exp 0011", br_mask_o); end
        rst = 1'b1; br_dispatch_i = 1'b1; br_rs_vld_i = 1'b1; br_rs_1hot_i = 4'b0001; br_rs_correct_i = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (br_mask_o !== 4'b0000) begin n_err++; $display("FAIL rm_mask got %b exp 0000", br_mask_o); end
        n_cmp++; if (br_cnt_o !== 3'd0) begin n_err++; $display("FAIL rm_cnt got %0d exp 0", br_cnt_o); end
        n_cmp++; if (br_full_o !== 1'b0) begin n_err++; $display("FAIL rm_full got %b exp 0", br_full_o); end
    endtask

    initial begin
        rst             = 1'b1;
        br_dispatch_i   = 1'b0;
        br_rs_vld_i     = 1'b0;
        br_rs_1hot_i    = 4'b0000;
        br_rs_correct_i = 1'b0;
        test_reset();
        test_fill();
        test_mispredict();
        test_correct();
        test_back_to_back();
        test_unqualified();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/br_mask_ctrl.md
Name: br_mask_ctrl

Overview:
- Branch-mask controller and allocator for the branch stack, one per core.
- Tracks which branch checkpoints are in flight and allocates a one-hot tag to each newly dispatched branch.
- Records each branch's dependency mask; on resolve, computes the next mask: clear on correct, roll back on mispredict.
- Drives the per-entry mask bits, resolving one-hot and branch state consumed by the branch stack entries, plus recovery select and squash mask for map table, free list and store queue.

Parameters:
- BR_NUM, 4, number of branch checkpoints (mask width).
- BR_STATE_W, 2, width of branch state encoding: NO_BR=2'b00, PR_CORRECT=2'b01, PR_WRONG=2'b10.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- br_dispatch_i  in  1  a branch dispatches this cycle.
- br_rs_vld_i  in  1  a branch resolves this cycle.
- br_rs_1hot_i  in  BR_NUM  one-hot tag of resolving branch.
- br_rs_correct_i  in  1  1=predicted correctly, 0=mispredicted.
- br_mask_o  out  BR_NUM  current in-flight mask (registered); bit i drives entry i's mask_bit_i.
- br_new_1hot_o  out  BR_NUM  tag allocated to the dispatching branch (combinational).
- br_dep_mask_o  out  BR_NUM  mask the dispatching instruction carries (combinational).
- br_accept_o  out  1  dispatch accepted this cycle.
- br_full_o  out  1  all BR_NUM bits in use (registered-derived).
- br_cnt_o  out  $clog2(BR_NUM)+1  number of in-flight branches (registered).
- br_state_o  out  BR_STATE_W  resolve state broadcast to entries.
- br_1hot_o  out  BR_NUM  qualified resolving one-hot broadcast to entries.
- rc_sel_o  out  BR_NUM  checkpoint to restore on mispredict, else 0.
- squash_mask_o  out  BR_NUM  branches killed by a mispredict, including itself.

Behaviour:
- State: mask_r[BR_NUM], dep_r[BR_NUM][BR_NUM] (per-entry dependency mask), cnt_r.
- Reset: mask_r=0, all dep_r=0, cnt_r=0.
  - Outputs then: br_mask_o=0, br_full_o=0, br_cnt_o=0.
  - With inputs idle: br_state_o=NO_BR, br_1hot_o=0, rc_sel_o=0, squash_mask_o=0, br_accept_o=0.
- Resolve qualification: rs_ok = br_rs_vld_i && (br_rs_1hot_i & mask_r) != 0 && br_rs_1hot_i is one-hot.
  - If the resolve is not rs_ok, it is ignored: no state change, br_state_o=NO_BR, br_1hot_o=0.
- Resolve outputs are combinational in the resolve cycle:
  - br_1hot_o = br_rs_1hot_i when rs_ok.
  - br_state_o = PR_CORRECT or PR_WRONG.
- Allocation:
  - br_new_1hot_o = lowest-index zero bit of mask_r, taken from mask_r only.
  - A bit freed this cycle is not reused until the next cycle.
- br_full_o = &mask_r.
- br_accept_o = br_dispatch_i && !br_full_o && !(rs_ok && !br_rs_correct_i).
- br_dep_mask_o:
  - mask_r & ~br_rs_1hot_i if a correct resolve happens the same cycle.
  - mask_r otherwise.
- Correct resolve (rs_ok && correct), applied at the next edge:
  - mask_r &= ~1hot.
  - Clear that bit in every dep_r[j].
  - cnt_r decrements.
- Mispredict (rs_ok && !correct), tag b:
  - rc_sel_o = 1hot.
  - squash_mask_o = mask_r & ~dep_r[b].
  - Next edge: mask_r = dep_r[b]; cnt_r = popcount(dep_r[b]).
  - dep_r of squashed entries is cleared to 0.
  - Any dispatch this cycle is rejected.
- Accepted dispatch, applied at the next edge:
  - Set bit k = br_new_1hot_o in mask_r.
  - dep_r[k] = br_dep_mask_o.
  - cnt_r increments.
- Correct resolve plus accepted dispatch in the same cycle: both apply; cnt_r is unchanged.
- Dispatch when full: br_accept_o=0, no state change. Upstream stalls.
- Checkpoint timing: mask bit k rises one edge after dispatch. Entry k therefore freezes the backup data present in the dispatch cycle.
- Reset mid-operation overrides all events in that cycle.

Test Plan:
- Reset, then dispatch 4 branches on consecutive cycles (BR_NUM=4) -> masks 0001, 0011, 0111, 1111; dep_r = 0000, 0001, 0011, 0111; br_full_o=1, br_cnt_o=4; 5th dispatch -> br_accept_o=0, mask unchanged.
- mask=0111, resolve 0010 correct -> br_state_o=01, br_1hot_o=0010; next mask=0101, cnt=2, dep_r[2]=0001.
- mask=1111, resolve 0010 wrong -> rc_sel_o=0010, squash_mask_o=1110, br_state_o=10; next mask=0001, cnt=1.
- mask=0011, dispatch + resolve 0001 correct same cycle -> new tag 0100, dep_mask_o=0010; next mask=0110, cnt=2.
- mask=0011, dispatch + resolve 0010 wrong same cycle -> br_accept_o=0; next mask=0001.
- mask=0001, resolve 0100 (not in flight) -> br_state_o=00, br_1hot_o=0, no state change; assert rst mid-sequence -> mask=0, cnt=0 next cycle.
